// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: next-PC selector codes,
// reset/bubble defaults and base opcode constants used by fetch, decode and EX.
package pipe_pkg;

   typedef enum logic [1:0] {
      NPC_PC4  = 2'd0,
      NPC_ALU  = 2'd1,
      NPC_JUMP = 2'd2,
      NPC_BR   = 2'd3
   } npc_op_e;

   // Opcode 0 is not a legal RV32I opcode, so the decoder reports have_inst=0
   localparam logic [31:0] DEF_BUBBLE_INST = 32'h0000_0000;
   localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Instruction addresses are word aligned; low two bits are simply dropped
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/pc/pc4/inst with hold (stall) and flush
// (bubble insertion). Flush takes priority over hold.
module if_id_reg
   import pipe_pkg::*;
#(
   parameter logic [31:0] BUBBLE_INST = DEF_BUBBLE_INST
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] d_pc,
   input  logic [31:0] d_pc4,
   input  logic [31:0] d_inst,
   output logic        q_valid,
   output logic [31:0] q_pc,
   output logic [31:0] q_pc4,
   output logic [31:0] q_inst
);

   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_pc4;
   logic [31:0] r_inst;

   // Bubble on reset/flush (pc fields zeroed so forwarding never matches), hold on stall, else load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= 32'h0;
         r_pc4   <= 32'h0;
         r_inst  <= BUBBLE_INST;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_pc    <= 32'h0;
         r_pc4   <= 32'h0;
         r_inst  <= BUBBLE_INST;
      end else if (!hold) begin
         r_valid <= 1'b1;
         r_pc    <= d_pc;
         r_pc4   <= d_pc4;
         r_inst  <= d_inst;
      end
   end

   assign q_valid = r_valid;
   assign q_pc    = r_pc;
   assign q_pc4   = r_pc4;
   assign q_inst  = r_inst;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// Optional feature macro FETCH_PERF_EN adds perf_fetched/perf_flushed counters.
module fetch_stage
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
   parameter logic [31:0] BUBBLE_INST = DEF_BUBBLE_INST
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] irom_addr,
   input  logic [31:0] irom_inst,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic [31:0] id_inst,
   output logic [6:0]  id_opcode,
   output logic [2:0]  id_funct3,
   output logic [6:0]  id_funct7
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed
`endif
);

   logic [31:0] r_pc;
   logic [31:0] w_pc4;
   logic [31:0] w_pc_next;

   assign w_pc4     = r_pc + 32'd4;   // wraps modulo 2^32 by width
   assign irom_addr = r_pc;

   // Next PC: redirect beats stall beats sequential advance
   always_comb begin
      w_pc_next = r_pc;
      if (redirect_valid) begin
         w_pc_next = align_pc(redirect_pc);
      end else if (!stall) begin
         w_pc_next = w_pc4;
      end
   end

   // PC register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   if_id_reg #(
      .BUBBLE_INST(BUBBLE_INST)
   ) u_if_id (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold   (stall),
      .flush  (redirect_valid),
      .d_pc   (r_pc),
      .d_pc4  (w_pc4),
      .d_inst (irom_inst),
      .q_valid(id_valid),
      .q_pc   (id_pc),
      .q_pc4  (id_pc4),
      .q_inst (id_inst)
   );

   // Decoder fields are plain slices of the registered instruction
   assign id_opcode = id_inst[6:0];
   assign id_funct3 = id_inst[14:12];
   assign id_funct7 = id_inst[31:25];

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_flushed;

   // Count advance edges and redirect edges; stalled edges count toward neither
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetched <= 32'h0;
         r_perf_flushed <= 32'h0;
      end else if (redirect_valid) begin
         r_perf_flushed <= r_perf_flushed + 32'd1;
      end else if (!stall) begin
         r_perf_fetched <= r_perf_fetched + 32'd1;
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage. Build with FETCH_PERF_EN
// defined to also check the performance counters.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] irom_addr;
   logic [31:0] irom_inst;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic [31:0] id_inst;
   logic [6:0]  id_opcode;
   logic [2:0]  id_funct3;
   logic [6:0]  id_funct7;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushed;
`endif

   fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .irom_addr     (irom_addr),
      .irom_inst     (irom_inst),
      .id_valid      (id_valid),
      .id_pc         (id_pc),
      .id_pc4        (id_pc4),
      .id_inst       (id_inst),
      .id_opcode     (id_opcode),
      .id_funct3     (id_funct3),
      .id_funct7     (id_funct7)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_flushed  (perf_flushed)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction ROM contents: two fixed words, pseudo-random elsewhere
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h00A0_0113;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   assign irom_inst = rom_word(irom_addr);

   typedef struct {
      logic [31:0] pc;
      logic        v;
      logic [31:0] ipc;
      logic [31:0] ipc4;
      logic [31:0] inst;
      logic [31:0] nfe;
      logic [31:0] nfl;
   } exp_t;

   exp_t exp_q[$];

   // Reference state: PC, ID slot and event counts
   logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_fe, m_fl;
   logic        m_v;

   int n_checks = 0;
   int n_errors = 0;
   int n_txn    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_inst = 32'h0;
      m_fe = 32'h0; m_fl = 32'h0;
   endtask

   // Drive one cycle of inputs mid-cycle and queue the state expected after the next edge
   task automatic step(input logic s, input logic rv, input logic [31:0] rpc);
      exp_t e;
      @(negedge clk);
      stall = s; redirect_valid = rv; redirect_pc = rpc;
      if (rv) begin
         m_pc = rpc & 32'hFFFF_FFFC;
         m_v = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_inst = 32'h0;
         m_fl = m_fl + 1;
      end else if (!s) begin
         m_v = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_inst = rom_word(m_pc);
         m_pc = m_pc + 32'd4;
         m_fe = m_fe + 1;
      end
      e.pc = m_pc; e.v = m_v; e.ipc = m_ipc; e.ipc4 = m_ipc4; e.inst = m_inst;
      e.nfe = m_fe; e.nfl = m_fl;
      exp_q.push_back(e);
   endtask

   // Monitor: just after each rising edge, compare the DUT against the oldest expectation
   initial begin
      exp_t e;
      logic [31:0] w;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            w = e.inst;
            n_txn++;
            $display("txn %0d: irom_addr=%h id_valid=%b id_pc=%h id_pc4=%h id_inst=%h",
                     n_txn, irom_addr, id_valid, id_pc, id_pc4, id_inst);
            chk("irom_addr", irom_addr, e.pc);
            chk("id_valid", {31'h0, id_valid}, {31'h0, e.v});
            chk("id_pc", id_pc, e.ipc);
            chk("id_pc4", id_pc4, e.ipc4);
            chk("id_inst", id_inst, e.inst);
            chk("id_opcode", {25'h0, id_opcode}, {25'h0, w[6:0]});
            chk("id_funct3", {29'h0, id_funct3}, {29'h0, w[14:12]});
            chk("id_funct7", {25'h0, id_funct7}, {25'h0, w[31:25]});
`ifdef FETCH_PERF_EN
            chk("perf_fetched", perf_fetched, e.nfe);
            chk("perf_flushed", perf_flushed, e.nfl);
`endif
         end
      end
   end

   task automatic check_reset_state(input string tag);
      chk({tag, "_irom_addr"}, irom_addr, 32'h0);
      chk({tag, "_id_valid"}, {31'h0, id_valid}, 32'h0);
      chk({tag, "_id_inst"}, id_inst, 32'h0);
      chk({tag, "_id_pc"}, id_pc, 32'h0);
      chk({tag, "_id_pc4"}, id_pc4, 32'h0);
`ifdef FETCH_PERF_EN
      chk({tag, "_perf_fetched"}, perf_fetched, 32'h0);
      chk({tag, "_perf_flushed"}, perf_flushed, 32'h0);
`endif
   endtask

   initial begin
      logic        s, rv;
      logic [31:0] rpc;
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check_reset_state("reset");

      // Streaming from 0, stall three edges at pc=8, advance to 0x10
      step(0, 0, 32'h0);
      step(0, 0, 32'h0);
      step(1, 0, 32'h0);
      step(1, 0, 32'h0);
      step(1, 0, 32'h0);
      step(0, 0, 32'h0);
      step(0, 0, 32'h0);
      // Misaligned redirect target, then redirect overriding a stall
      step(0, 1, 32'h0000_0041);
      step(0, 0, 32'h0);
      step(1, 1, 32'h0000_0080);
      step(0, 0, 32'h0);
      // PC wrap past the top of the address space
      step(0, 1, 32'hFFFF_FFFC);
      step(0, 0, 32'h0);
      step(0, 0, 32'h0);
      step(0, 0, 32'h0);

      // Random mix of stalls and redirects, occasionally near the wrap point
      for (int i = 0; i < 300; i++) begin
         s   = ($urandom_range(0, 3) == 0);
         rv  = ($urandom_range(0, 9) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
         step(s, rv, rpc);
      end

      // Asynchronous reset asserted while stalled, released, then a normal fetch
      step(1, 0, 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_state("async_reset");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step(0, 0, 32'h0);

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
